// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register feeding the RV32I ALU.
// Decodes OP / OP-IMM / LUI / AUIPC into ALU operands and an ALU opcode.
// Holds the result in a one-entry valid/ready output register.
// The output register supports backpressure, flush and illegal-instruction flagging.
module alu_issue_stage #(
    parameter bit SHAMT_MASK  = 1'b1,
    parameter bit X0_NO_WRITE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [3:0]  ALU_OP,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    // Decode-side signals (combinational, from the incoming packet).
    logic [6:0]  opcode_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_u_s;
    logic [31:0] shamt_i_s;
    logic [31:0] dec_a_s;
    logic [31:0] dec_b_s;
    logic [3:0]  dec_op_s;
    logic        dec_legal_s;
    logic [31:0] fin_a_s;
    logic [31:0] fin_b_s;
    logic [3:0]  fin_op_s;
    logic        fin_we_s;
    logic        accept_s;

    // Output-register state.
    logic        valid_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [3:0]  op_r;
    logic [4:0]  rd_r;
    logic        we_r;
    logic        ill_r;

    // No skid buffer: accept only when the holding register is empty or draining.
    assign in_ready = !valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Decode the incoming instruction into operands, ALU opcode and legality.
    always_comb begin
        opcode_s    = in_instr[6:0];
        f3_s        = in_instr[14:12];
        f7_s        = in_instr[31:25];
        rd_s        = in_instr[11:7];
        imm_i_s     = {{20{in_instr[31]}}, in_instr[31:20]};
        imm_u_s     = {in_instr[31:12], 12'h000};
        shamt_i_s   = {27'd0, in_instr[24:20]};
        dec_a_s     = 32'h0000_0000;
        dec_b_s     = 32'h0000_0000;
        dec_op_s    = ALU_ADD;
        dec_legal_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                dec_a_s  = in_rs1;
                dec_op_s = {1'b0, f3_s};
                if (f7_s == F7_ZERO) begin
                    dec_legal_s = 1'b1;
                end else if ((f7_s == F7_ALT) && ((f3_s == 3'b000) || (f3_s == 3'b101))) begin
                    dec_legal_s = 1'b1;
                    dec_op_s    = (f3_s == 3'b000) ? ALU_SUB : ALU_SRA;
                end else begin
                    dec_legal_s = 1'b0;
                end
                // The ALU shifts by the full B operand, so register shifts are trimmed here.
                if (SHAMT_MASK && ((f3_s == 3'b001) || (f3_s == 3'b101))) begin
                    dec_b_s = {27'd0, in_rs2[4:0]};
                end else begin
                    dec_b_s = in_rs2;
                end
            end
            OPC_OPIMM: begin
                dec_a_s     = in_rs1;
                dec_b_s     = imm_i_s;
                dec_op_s    = {1'b0, f3_s};
                dec_legal_s = 1'b1;
                case (f3_s)
                    3'b001: begin
                        dec_b_s     = shamt_i_s;
                        dec_legal_s = (f7_s == F7_ZERO);
                    end
                    3'b101: begin
                        dec_b_s = shamt_i_s;
                        if (f7_s == F7_ZERO) begin
                            dec_op_s    = ALU_SRL;
                            dec_legal_s = 1'b1;
                        end else if (f7_s == F7_ALT) begin
                            dec_op_s    = ALU_SRA;
                            dec_legal_s = 1'b1;
                        end else begin
                            dec_legal_s = 1'b0;
                        end
                    end
                    default: begin
                        dec_b_s = imm_i_s;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_a_s     = 32'h0000_0000;
                dec_b_s     = imm_u_s;
                dec_op_s    = ALU_ADD;
                dec_legal_s = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a_s     = in_pc;
                dec_b_s     = imm_u_s;
                dec_op_s    = ALU_ADD;
                dec_legal_s = 1'b1;
            end
            default: begin
                dec_legal_s = 1'b0;
            end
        endcase
        // Illegal packets still occupy the stage but carry neutral operands.
        if (dec_legal_s) begin
            fin_a_s  = dec_a_s;
            fin_b_s  = dec_b_s;
            fin_op_s = dec_op_s;
        end else begin
            fin_a_s  = 32'h0000_0000;
            fin_b_s  = 32'h0000_0000;
            fin_op_s = ALU_ADD;
        end
        fin_we_s = dec_legal_s && !(X0_NO_WRITE && (rd_s == 5'd0));
    end

    // One-entry output register: reset > flush > accept > drain > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            a_r     <= 32'h0000_0000;
            b_r     <= 32'h0000_0000;
            op_r    <= 4'b0000;
            rd_r    <= 5'd0;
            we_r    <= 1'b0;
            ill_r   <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            a_r     <= fin_a_s;
            b_r     <= fin_b_s;
            op_r    <= fin_op_s;
            rd_r    <= rd_s;
            we_r    <= fin_we_s;
            ill_r   <= !dec_legal_s;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid   = valid_r;
    assign ALU_A       = a_r;
    assign ALU_B       = b_r;
    assign ALU_OP      = op_r;
    assign out_rd      = rd_r;
    assign out_rd_we   = we_r;
    assign out_illegal = ill_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage.
// Uses a table of decoded packets, then hand-written backpressure, flush and reset sequences.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1, in_rs2, alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_illegal;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op, input logic [4:0] rd,
                                input logic we, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.a = a; v.b = b; v.op = op; v.rd = rd; v.we = we; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_instr = v.instr;
        in_pc    = v.pc;
        in_rs1   = v.rs1;
        in_rs2   = v.rs2;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".A"}, alu_a, v.a);
        chk({tag, ".B"}, alu_b, v.b);
        chk({tag, ".op"}, {28'd0, alu_op}, {28'd0, v.op});
        chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, v.rd});
        chk({tag, ".we"}, {31'd0, out_rd_we}, {31'd0, v.we});
        chk({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, v.ill});
    endtask

    initial begin
        vec_t v_add, v_or;
        // Opcode constants
        // OP=0110011 OPIMM=0010011 LUI=0110111 AUIPC=0010111 LOAD=0000011
        vq.push_back(mk(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h0, 32'd5, 32'd7,
                        32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0));                       // ADD
        vq.push_back(mk(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h0, 32'd10, 32'd3,
                        32'd10, 32'd3, 4'b1000, 5'd3, 1'b1, 1'b0));                      // SUB
        vq.push_back(mk(enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd4, 7'b0110011), 32'h0, 32'h8000_0000,
                        32'h0000_0123, 32'h8000_0000, 32'h0000_0003, 4'b1001, 5'd4, 1'b1, 1'b0)); // SRA
        vq.push_back(mk(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd5, 7'b0110011), 32'h0, 32'd3,
                        32'hFFFF_FFE5, 32'd3, 32'd5, 4'b0001, 5'd5, 1'b1, 1'b0));         // SLL
        vq.push_back(mk(enc_i(12'hFFF, 5'd1, 3'b000, 5'd6, 7'b0010011), 32'h0, 32'd1, 32'd99,
                        32'd1, 32'hFFFF_FFFF, 4'b0000, 5'd6, 1'b1, 1'b0));                // ADDI -1
        vq.push_back(mk(enc_i({7'b0100000, 5'd31}, 5'd1, 3'b101, 5'd7, 7'b0010011), 32'h0,
                        32'h1234_5678, 32'd0, 32'h1234_5678, 32'd31, 4'b1001, 5'd7, 1'b1, 1'b0)); // SRAI 31
        vq.push_back(mk(enc_i(12'h800, 5'd1, 3'b011, 5'd8, 7'b0010011), 32'h0, 32'd42, 32'd0,
                        32'd42, 32'hFFFF_F800, 4'b0011, 5'd8, 1'b1, 1'b0));               // SLTIU
        vq.push_back(mk({20'hABCDE, 5'd5, 7'b0010111}, 32'h0000_0100, 32'd1, 32'd2,
                        32'h0000_0100, 32'hABCD_E000, 4'b0000, 5'd5, 1'b1, 1'b0));        // AUIPC
        vq.push_back(mk({20'h12345, 5'd0, 7'b0110111}, 32'h0000_0200, 32'd1, 32'd2,
                        32'd0, 32'h1234_5000, 4'b0000, 5'd0, 1'b0, 1'b0));                // LUI x0
        vq.push_back(mk(enc_i(12'h004, 5'd1, 3'b010, 5'd9, 7'b0000011), 32'h0, 32'd77, 32'd88,
                        32'd0, 32'd0, 4'b0000, 5'd9, 1'b0, 1'b1));                        // LOAD
        vq.push_back(mk(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd10, 7'b0110011), 32'h0, 32'd6, 32'd7,
                        32'd0, 32'd0, 4'b0000, 5'd10, 1'b0, 1'b1));                       // MUL
        vq.push_back(mk(enc_i({7'b0100000, 5'd3}, 5'd1, 3'b001, 5'd11, 7'b0010011), 32'h0, 32'd6,
                        32'd7, 32'd0, 32'd0, 4'b0000, 5'd11, 1'b0, 1'b1));                // bad SLLI
        vq.push_back(mk(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd12, 7'b0110011), 32'h0, 32'h0000_00F0,
                        32'h0000_000F, 32'h0000_00F0, 32'h0000_000F, 4'b0110, 5'd12, 1'b1, 1'b0)); // OR
        vq.push_back(mk(enc_r(7'h20, 5'd2, 5'd1, 3'b001, 5'd13, 7'b0110011), 32'h0, 32'd6, 32'd7,
                        32'd0, 32'd0, 4'b0000, 5'd13, 1'b0, 1'b1));                       // bad SLL
        v_add = vq[0];
        v_or  = vq[12];

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(vq[0]);

        // Reset for two cycles.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.A", alu_a, 32'd0);
        chk("rst.B", alu_b, 32'd0);
        chk("rst.op", {28'd0, alu_op}, 32'd0);
        chk("rst.rd", {27'd0, out_rd}, 32'd0);
        chk("rst.we", {31'd0, out_rd_we}, 32'd0);
        chk("rst.ill", {31'd0, out_illegal}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle.valid", {31'd0, out_valid}, 32'd0);

        // Table of decoded packets, one per cycle with the consumer always ready.
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_outputs($sformatf("vec%0d", i), vq[i]);
        end

        // Backpressure: hold ADD for 3 cycles while OR waits, then release.
        @(negedge clk);
        drive(v_add); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("bp.load", v_add);
        @(negedge clk);
        out_ready = 1'b0;
        drive(v_or);
        #1;
        chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_outputs($sformatf("bp.hold%0d", c), v_add);
            chk($sformatf("bp.in_ready%0d", c), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_outputs("bp.next", v_or);
        @(posedge clk);
        #1;
        chk("bp.drain", {31'd0, out_valid}, 32'd0);

        // Flush drops a same-cycle accept.
        @(negedge clk);
        drive(v_add); in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush.accept", {31'd0, out_valid}, 32'd0);

        // Flush kills a held entry under backpressure.
        @(negedge clk);
        drive(v_or); in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("flush.pre", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush.held", {31'd0, out_valid}, 32'd0);

        // Reset wins over flush and clears the payload.
        @(negedge clk);
        out_ready = 1'b1; drive(v_or); in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
        chk("rstflush.valid", {31'd0, out_valid}, 32'd0);
        chk("rstflush.A", alu_a, 32'd0);
        chk("rstflush.rd", {27'd0, out_rd}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
